// File: rtl/dw_conv_pkg.sv
// Shared constants and FSM encoding for the depthwise 3x3 column feeder.
// The pad states are only reachable when DWF_PAD_EN is defined.
package dw_conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int IMG_W_DEF  = 16;
    localparam int COL_W      = $clog2(IMG_W_DEF);

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_STREAM = 3'd1;
    localparam state_t ST_DONE   = 3'd2;
    localparam state_t ST_PAD_L  = 3'd3;
    localparam state_t ST_PAD_R  = 3'd4;
    localparam state_t ST_FLUSH  = 3'd5;

    function automatic int col_w(input int img_w);
        return (img_w > 1) ? $clog2(img_w) : 1;
    endfunction

endpackage

// File: rtl/dw_col_feeder_if.sv
// Pixel input stream plus column-triple output bus of the window feeder.
// The slave modport is the feeder side; master is the surrounding environment.
interface dw_col_feeder_if
    import dw_conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic signed [DATA_W-1:0] out_r0_c;
    logic signed [DATA_W-1:0] out_r1_c;
    logic signed [DATA_W-1:0] out_r2_c;
    logic                     out_valid;

    modport master (
        output s_valid, s_data,
        input  s_ready, out_r0_c, out_r1_c, out_r2_c, out_valid
    );

    modport slave (
        input  s_valid, s_data,
        output s_ready, out_r0_c, out_r1_c, out_r2_c, out_valid
    );
endinterface

// File: rtl/dwf_line_buffer.sv
// One row of pixels with a single shared address: combinational read, write on enable.
// Contents are deliberately not reset; the feeder never emits a location before writing it.
module dwf_line_buffer
    import dw_conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int AW     = col_w(IMG_W)
) (
    input  logic                     clk,
    input  logic [AW-1:0]            addr,
    input  logic                     we,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata
);
    logic signed [DATA_W-1:0] mem_q [IMG_W];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end
endmodule

// File: rtl/dw_col_feeder.sv
// Raster-order pixel stream to vertically aligned column triples (rows y-1, y, y+1).
// Define DWF_PAD_EN for "same" padding: framing pad beats, top-row masking and a final flush row.
module dw_col_feeder
    import dw_conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             frame_done,
    dw_col_feeder_if.slave   bus
);
    localparam int AW = col_w(IMG_W);
    localparam int RW = $clog2(IMG_H + 2);
    localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - 1);
`ifdef DWF_PAD_EN
    localparam logic [RW-1:0] ROW_IN_END  = RW'(IMG_H);
    localparam logic [RW-1:0] ROW_FLUSHED = RW'(IMG_H + 1);
`else
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
`endif

    state_t                   state_q, state_d;
    logic [AW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic                     s_ready_q, s_ready_d;
    logic                     busy_q, busy_d;
    logic                     frame_done_q, frame_done_d;
    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_r0_q, out_r0_d;
    logic signed [DATA_W-1:0] out_r1_q, out_r1_d;
    logic signed [DATA_W-1:0] out_r2_q, out_r2_d;
    logic signed [DATA_W-1:0] lb0_rd, lb1_rd;
    logic                     accept;
    logic                     col_wrap;
    logic [AW-1:0]            col_nxt;

    assign accept   = bus.s_valid && s_ready_q;
    assign col_wrap = (col_q == COL_LAST);
    assign col_nxt  = col_wrap ? '0 : col_q + AW'(1);

    // LB0 holds row y-2, LB1 row y-1; both shift down one row on every accepted pixel.
    dwf_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(AW)) u_lb0 (
        .clk   (clk),
        .addr  (col_q),
        .we    (accept),
        .wdata (lb1_rd),
        .rdata (lb0_rd)
    );

    dwf_line_buffer #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(AW)) u_lb1 (
        .clk   (clk),
        .addr  (col_q),
        .we    (accept),
        .wdata (bus.s_data),
        .rdata (lb1_rd)
    );

    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        out_valid_d  = 1'b0;
        out_r0_d     = out_r0_q;
        out_r1_d     = out_r1_q;
        out_r2_d     = out_r2_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    col_d   = '0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_STREAM: begin
                if (accept) begin
                    col_d = col_nxt;
                    if (col_wrap) row_d = row_q + RW'(1);
`ifdef DWF_PAD_EN
                    if (row_q >= RW'(1)) begin
                        out_valid_d = 1'b1;
                        out_r0_d    = (row_q == RW'(1)) ? '0 : lb0_rd;
                        out_r1_d    = lb1_rd;
                        out_r2_d    = bus.s_data;
                    end
                    if (col_wrap) state_d = (row_q == '0) ? ST_PAD_L : ST_PAD_R;
`else
                    if (row_q >= RW'(2)) begin
                        out_valid_d = 1'b1;
                        out_r0_d    = lb0_rd;
                        out_r1_d    = lb1_rd;
                        out_r2_d    = bus.s_data;
                    end
                    if (col_wrap && row_q == ROW_LAST) state_d = ST_DONE;
`endif
                end
            end
`ifdef DWF_PAD_EN
            ST_PAD_L: begin
                out_valid_d = 1'b1;
                out_r0_d    = '0;
                out_r1_d    = '0;
                out_r2_d    = '0;
                state_d     = (row_q == ROW_IN_END) ? ST_FLUSH : ST_STREAM;
            end
            ST_PAD_R: begin
                out_valid_d = 1'b1;
                out_r0_d    = '0;
                out_r1_d    = '0;
                out_r2_d    = '0;
                state_d     = (row_q == ROW_FLUSHED) ? ST_DONE : ST_PAD_L;
            end
            // Last output row has no row below it; read the buffers out without input.
            ST_FLUSH: begin
                out_valid_d = 1'b1;
                out_r0_d    = lb0_rd;
                out_r1_d    = lb1_rd;
                out_r2_d    = '0;
                col_d       = col_nxt;
                if (col_wrap) begin
                    row_d   = row_q + RW'(1);
                    state_d = ST_PAD_R;
                end
            end
`endif
            ST_DONE: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        s_ready_d = (state_d == ST_STREAM);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            col_q        <= '0;
            row_q        <= '0;
            s_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_r0_q     <= '0;
            out_r1_q     <= '0;
            out_r2_q     <= '0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            s_ready_q    <= s_ready_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            out_valid_q  <= out_valid_d;
            out_r0_q     <= out_r0_d;
            out_r1_q     <= out_r1_d;
            out_r2_q     <= out_r2_d;
        end
    end

    assign bus.s_ready   = s_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_r0_c  = out_r0_q;
    assign bus.out_r1_c  = out_r1_q;
    assign bus.out_r2_c  = out_r2_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
endmodule

// File: tb/tb_dw_col_feeder.sv
// Directed bench for dw_col_feeder on a 4x4 frame with pixel(y,x) = 4y+x+1.
// Default build checks the valid-only mode; with DWF_PAD_EN it checks the padded frame.
`timescale 1ns/1ps
module tb_dw_col_feeder;
    import dw_conv_pkg::*;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;

    typedef struct {
        logic signed [DW-1:0] d;
        logic                 ev;
        logic signed [DW-1:0] e0;
        logic signed [DW-1:0] e1;
        logic signed [DW-1:0] e2;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0;
    logic busy, frame_done;
    logic acc;
    int   n_run = 0;
    int   n_fail = 0;
    vec_t tbl [W*H];

    dw_col_feeder_if #(.DATA_W(DW)) bus ();

    dw_col_feeder #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs; acc reports whether the beat is taken at this edge.
    task automatic step(input logic v, input logic signed [DW-1:0] d, input logic st, output logic a);
        bus.s_valid = v;
        bus.s_data  = d;
        start       = st;
        a           = v && bus.s_ready;
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic do_start();
        logic a;
        step(1'b0, '0, 1'b1, a);
        chk("start_busy", busy, 1);
        chk("start_ready", bus.s_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_r0"}, bus.out_r0_c, 0);
        chk({tag, "_r1"}, bus.out_r1_c, 0);
        chk({tag, "_r2"}, bus.out_r2_c, 0);
        chk({tag, "_ready"}, bus.s_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, frame_done, 0);
    endtask

    task automatic run_tbl(input int n, input bit gaps, input bit st_mid);
        logic a;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                step(1'b0, '0, 1'b0, a);
                chk("gap_valid", bus.out_valid, 0);
            end
            step(1'b1, tbl[i].d, st_mid && (i == 5 || i == W*H-1), a);
            chk("accept", a, 1);
            chk("out_valid", bus.out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                chk("r0", bus.out_r0_c, tbl[i].e0);
                chk("r1", bus.out_r1_c, tbl[i].e1);
                chk("r2", bus.out_r2_c, tbl[i].e2);
            end
        end
        if (n == W*H) begin
            step(1'b0, '0, 1'b0, a);
            chk("frame_done", frame_done, 1);
            chk("busy_fall", busy, 0);
            chk("valid_after_last", bus.out_valid, 0);
            step(1'b0, '0, 1'b0, a);
            chk("done_one_cycle", frame_done, 0);
            chk("idle_busy", busy, 0);
            chk("idle_ready", bus.s_ready, 0);
        end
    endtask

`ifdef DWF_PAD_EN
    function automatic int pix(input int y, input int x);
        return 4*y + x + 1;
    endfunction
`endif

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                tbl[y*W+x].d  = DW'(4*y + x + 1);
                tbl[y*W+x].ev = (y >= 2);
                tbl[y*W+x].e0 = DW'(4*(y-2) + x + 1);
                tbl[y*W+x].e1 = DW'(4*(y-1) + x + 1);
                tbl[y*W+x].e2 = DW'(4*y + x + 1);
            end
        end

        #1 rst_n = 1'b0;
        #3;
        chk_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // s_valid in IDLE must not be taken.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 8'sd99, 1'b0, acc);
            chk("idle_accept", acc, 0);
            chk("idle_busy", busy, 0);
            chk("idle_out_valid", bus.out_valid, 0);
        end

`ifndef DWF_PAD_EN
        do_start();
        run_tbl(W*H, 1'b0, 1'b0);

        do_start();
        run_tbl(W*H, 1'b1, 1'b0);

        // Abort after six output beats, then a clean frame.
        do_start();
        run_tbl(2*W + 6, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("abort");
        @(posedge clk);
        #1 rst_n = 1'b1;
        do_start();
        run_tbl(W*H, 1'b0, 1'b0);

        // start pulses mid-frame and alongside the final beat are ignored.
        do_start();
        run_tbl(W*H, 1'b0, 1'b1);

        // Extreme signed values at column 0 pass through untouched.
        do_start();
        for (int i = 0; i < W*H; i++) begin
            logic signed [DW-1:0] d;
            d = (i == 0 || i == 2*W) ? -8'sd128 : (i == W) ? 8'sd127 : 8'sd0;
            step(1'b1, d, 1'b0, acc);
            if (i == 2*W) begin
                chk("signed_valid", bus.out_valid, 1);
                chk("signed_r0", bus.out_r0_c, -128);
                chk("signed_r1", bus.out_r1_c, 127);
                chk("signed_r2", bus.out_r2_c, -128);
            end
        end
        step(1'b0, '0, 1'b0, acc);
        chk("signed_done", frame_done, 1);
`else
        begin
            int k, nb, row, j, e0, e1, e2;
            logic got_done;
            k = 0;
            nb = 0;
            got_done = 1'b0;
            do_start();
            for (int c = 0; c < 200 && !got_done; c++) begin
                step(k < W*H, DW'(k + 1), 1'b0, acc);
                if (acc) k++;
                if (frame_done) got_done = 1'b1;
                if (bus.out_valid) begin
                    row = nb / (W + 2);
                    j   = nb % (W + 2);
                    if (j == 0 || j == W + 1) begin
                        e0 = 0; e1 = 0; e2 = 0;
                    end else begin
                        e0 = (row > 0) ? pix(row - 1, j - 1) : 0;
                        e1 = pix(row, j - 1);
                        e2 = (row < H - 1) ? pix(row + 1, j - 1) : 0;
                    end
                    chk("pad_r0", bus.out_r0_c, e0);
                    chk("pad_r1", bus.out_r1_c, e1);
                    chk("pad_r2", bus.out_r2_c, e2);
                    if (j == 0 || j == W + 1 || row == H - 1) chk("pad_no_accept", acc, 0);
                    nb++;
                end
            end
            chk("pad_frame_done", got_done, 1);
            chk("pad_beats", nb, H*(W+2));
            chk("pad_pixels", k, W*H);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/dw_col_feeder.md
# dw_col_feeder

Column-serial window feeder for the depthwise 3×3 datapath. Accepts a raster-order single-channel feature map, one pixel per beat, over a valid/ready input. Keeps the two previous rows in line buffers and emits, each cycle, three vertically aligned pixels of one column (rows y-1, y, y+1 of the window) with a valid strobe. It is the transmitter side of the row-convolution module's `in_r*_c` / `in_valid` input. The downstream module has no backpressure, so every asserted `out_valid` beat is consumed.

## Interface
- `DATA_W`, 8, pixel width (signed two's complement)
- `IMG_W`, 16, columns per row (≥3)
- `IMG_H`, 16, rows per frame (≥3)
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-cycle frame start pulse; ignored unless idle
- `s_valid`  in  1  input pixel valid
- `s_ready`  out  1  feeder accepts pixel this cycle
- `s_data`  in  DATA_W  input pixel, raster order
- `out_r0_c`  out  DATA_W  top-row pixel of current column
- `out_r1_c`  out  DATA_W  middle-row pixel
- `out_r2_c`  out  DATA_W  bottom-row pixel
- `out_valid`  out  1  column triple valid
- `busy`  out  1  high from accepted `start` until `frame_done`
- `frame_done`  out  1  one-cycle pulse after the last output beat of a frame

## Operation
- States: IDLE, STREAM, DONE. With `DWF_PAD_EN`, PAD_L, PAD_R and FLUSH are added.
- IDLE → STREAM on `start`. This clears `col_cnt` and `row_cnt`.
- A beat is accepted when `s_valid && s_ready`. `s_ready` is 1 only in STREAM.
- Line buffers LB0 (row y-2) and LB1 (row y-1) are indexed by `col_cnt`.
- On an accepted pixel p at column x: r0=LB0[x], r1=LB1[x], r2=p. The buffers then update LB0[x]←LB1[x] and LB1[x]←p, reading before writing.
- On an accepted beat, `col_cnt` wraps at IMG_W-1 and `row_cnt` increments on each wrap.
- No pad mode:
  - Rows 0 and 1 only fill the buffers.
  - Rows 2..IMG_H-1 each produce IMG_W beats, for (IMG_H-2)·IMG_W output beats in total.
  - After the last pixel the FSM goes to DONE, pulses `frame_done`, then returns to IDLE.
- Gaps in `s_valid` produce no output and no state change.
- Arithmetic: none. Data passes through bit-exact, and signed values are preserved.

## Timing
- All outputs are registered.
- `out_valid` and the column triple appear the cycle after the accepted beat (latency 1).
- `frame_done` is asserted in the cycle after the final `out_valid`. `busy` falls in that same cycle.
- Reset values:
  - All `out_*`, `s_ready`, `busy` and `frame_done` reset to 0; the state resets to IDLE.
  - Line buffer contents are not reset, and their stale values are never emitted.
- Reset mid-frame aborts immediately. The next `start` begins a clean frame.
- `start` while busy, including in the same cycle as the final beat, is ignored.
- `s_valid` in IDLE or DONE is not accepted.
- Output beats are contiguous only if input beats are contiguous.

## Configuration
- `DWF_PAD_EN` defined: same-size ("same") padding.
  - Output rows 0..IMG_H-1, each IMG_W+2 beats.
  - Output row y is emitted while input row y+1 arrives.
  - Input row 0 only fills the buffers.
  - Each output row is framed by PAD_L and PAD_R, each emitting (0,0,0) with `s_ready`=0.
  - In output row 0, r0 is forced to 0.
  - After input row IMG_H-1, FLUSH emits output row IMG_H-1 from r0=LB0[x], r1=LB1[x], r2=0, with `s_ready`=0.
  - Total output is IMG_H·(IMG_W+2) beats.
- Undefined: valid-only output as described under Operation; the pad states and masking logic are absent.

## Structure
- Package `dw_conv_pkg`: default `DATA_W`, the state enum, and `COL_W = $clog2(IMG_W)`.
- Sub-module `dwf_line_buffer`: IMG_W×DATA_W register array with one address, combinational read and synchronous write on enable (read-before-write). It is instantiated twice.

## Test plan
Parameters for all scenarios: IMG_W=4, IMG_H=4, pixel(y,x)=4y+x+1.

- No pad, continuous input:
  - Exactly 8 beats.
  - The first beat, one cycle after pixel 9 is accepted, is (1,5,9). The last beat is (8,12,16).
  - `frame_done` pulses one cycle after the last beat.
- No pad, `s_valid` toggling every other cycle: same 8 triples, with `out_valid` only one cycle after each accepted beat.
- `DWF_PAD_EN`:
  - 24 beats.
  - Row 0: (0,0,0),(0,1,5),(0,2,6),(0,3,7),(0,4,8),(0,0,0).
  - Row 3: (0,0,0),(9,13,0),(10,14,0),(11,15,0),(12,16,0),(0,0,0).
  - `s_ready`=0 during pad and flush beats.
- `rst_n` low after 6 beats:
  - All outputs go to 0 immediately.
  - After release and a new `start`, the output is identical to the first scenario.
- `start` asserted mid-frame and `s_valid` held high in IDLE: neither changes state, and no pixel is accepted in IDLE.
- Signed pass-through: pixels -128 and 127 at column 0 of rows 0..2 yield the triple (-128,127,-128) unchanged.
